ahb_arbiter_param: RTL
======================

Name: ahb_arbiter_param

Overview:
- Parametrised AHB bus arbiter for MASTER_NUM masters.
- Receives per-master hbusreq/hlock and drives one-hot hgrant, hmaster and hmastlock.
- Adds selectable fixed-priority or round-robin modes, locked-sequence hold and a burst beat limit.
- Sits between the master request interfaces and the decoder/mux; successor of the fixed 4-bit hmaster arbiter.

Parameters:
- MASTER_NUM, 4, number of masters (2..16).
- HMASTER_W, 4, width of hmaster (>= clog2(MASTER_NUM)).
- DEFAULT_MASTER, MASTER_NUM-1, index parked on when no request is active.
- ARB_MODE, 0, 0 = fixed priority (index 0 highest), 1 = round-robin.
- BURST_LIMIT, 0, max beats before forced re-arbitration mid-burst; 0 = unlimited.

Ports:
- hclk  input  1  bus clock.
- hreset  input  1  synchronous reset, active-high.
- hbusreq  input  MASTER_NUM  per-master bus request.
- hlock  input  MASTER_NUM  per-master locked-transfer request.
- hready  input  1  transfer-complete from slave mux.
- htrans  input  2  current owner's transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hgrant  output  MASTER_NUM  one-hot grant, registered.
- hmaster  output  HMASTER_W  index of address-phase owner, registered.
- hmastlock  output  1  locked indication, combinational.

Behaviour:
- Reset (hreset=1 at posedge hclk):
  - hgrant = 1<<DEFAULT_MASTER; hmaster = DEFAULT_MASTER.
  - rr_ptr = 0; beat_cnt = 0; state = PARK.
  - hmastlock follows its combinational rule from the reset grant, i.e. hlock[DEFAULT_MASTER].
  - Reset mid-burst or mid-lock aborts immediately.
- All state updates only at posedge hclk with hready=1. With hready=0, hgrant, hmaster, state and beat_cnt hold.
- hgrant is always exactly one-hot, never zero.
- hmaster <= index(hgrant) at every hready=1 edge, so it lags a grant change by one hready cycle (grant -> address-phase handover).
- hmastlock = hlock[index(hgrant)], combinational, same cycle.
- Winner selection:
  - Fixed mode: lowest-index requester wins.
  - RR mode: first requester scanning from rr_ptr upward, wrapping at MASTER_NUM-1 -> 0. rr_ptr <= winner+1 (mod MASTER_NUM) whenever the grant moves to a requester.
- No requester (hbusreq == 0): grant moves to DEFAULT_MASTER.
- FSM states:
  - PARK: default master granted, no request pending. A request moves to OWN with the winner.
  - OWN: a requesting master owns the bus.
    - Owner hlock=1 -> LOCKED, grant held.
    - Re-arbitration is allowed if htrans is IDLE or NONSEQ, or if (BURST_LIMIT != 0 and beat_cnt == BURST_LIMIT-1).
    - On re-arbitration the grant moves to the winner; if no requester, grant moves to DEFAULT_MASTER and state -> PARK.
    - If the owner still requests and is the winner, the grant stays.
  - LOCKED: grant held regardless of other requests or BURST_LIMIT. Owner hlock=0 at a hready edge -> UNLOCK, grant held.
  - UNLOCK: grant held for one more hready transfer (last locked data phase), then -> OWN re-arbitration rules.
- beat_cnt:
  - Increments on hready=1 with htrans NONSEQ/SEQ.
  - Clears on grant change or on htrans NONSEQ (new burst starts at 1).
  - Saturates at BURST_LIMIT-1.
- Simultaneous requests: resolved by mode in one cycle. An owner dropping hbusreq mid-burst keeps the grant until the burst-boundary rule allows a move.
- Requests asserted during hready=0 are ignored until the next hready=1 edge.

Optional Feature:
- AHB_ARB_SVA_EN: compiles in concurrent assertions, disabled during hreset=1:
  - $onehot(hgrant).
  - Grant change with hready implies next-edge hmaster = new index.
  - hmastlock == hlock[index(hgrant)].
  - hbusreq==0 && hready implies next hgrant == 1<<DEFAULT_MASTER.
  - Grant never changes in LOCKED.
- Without the macro, no assertion code exists and RTL behaviour is identical.

Test Plan:
- Reset, then no requests, hready=1 -> hgrant=4'b1000, hmaster=3, hmastlock=0 held indefinitely.
- Fixed mode, hbusreq=4'b0110 -> hgrant=4'b0010 next edge, hmaster=1 one hready edge later; master 1 drops request -> grant 4'b0100.
- RR mode, hbusreq=4'b1111 constant, htrans=NONSEQ every cycle -> grant sequence 0,1,2,3,0 over successive hready edges.
- Master 2 granted with hlock=1, master 0 requesting -> hmastlock=1, grant held; hlock drops -> grant held one more transfer, then hgrant=4'b0001.
- BURST_LIMIT=4, master 3 SEQ burst of 8 beats, master 1 requesting -> grant moves to master 1 after beat 4; with BURST_LIMIT=0 it moves only after the burst ends.
- hready=0 for 5 cycles while hbusreq changes -> hgrant/hmaster frozen; hreset mid-LOCKED -> default grant next edge.

Source files
------------

// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB bus arbiter: fixed-priority or round-robin winner selection,
// locked-sequence hold and an optional burst beat limit.
// Define AHB_ARB_SVA_EN to compile in the concurrent protocol assertions.
module ahb_arbiter_param #(
  parameter int unsigned MASTER_NUM     = 4,
  parameter int unsigned HMASTER_W      = 4,
  parameter int unsigned DEFAULT_MASTER = MASTER_NUM - 1,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned BURST_LIMIT    = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [MASTER_NUM-1:0] hbusreq,
  input  logic [MASTER_NUM-1:0] hlock,
  input  logic                  hready,
  input  logic [1:0]            htrans,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [HMASTER_W-1:0]  hmaster,
  output logic                  hmastlock
);

  localparam int unsigned IDX_W  = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int unsigned BEAT_W = (BURST_LIMIT > 2) ? $clog2(BURST_LIMIT) : 1;
  localparam logic [BEAT_W-1:0]     BEAT_MAX = BEAT_W'((BURST_LIMIT == 0) ? 0 : BURST_LIMIT - 1);
  localparam logic [MASTER_NUM-1:0] DEF_OH   = MASTER_NUM'(1) << DEFAULT_MASTER;
  localparam logic [IDX_W-1:0]      DEF_IDX  = IDX_W'(DEFAULT_MASTER);
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  typedef enum logic [1:0] {
    ST_PARK,
    ST_OWN,
    ST_LOCKED,
    ST_UNLOCK
  } state_t;

  state_t                  state_q, nxt_state;
  logic [MASTER_NUM-1:0]   nxt_grant;
  logic [IDX_W-1:0]        rr_ptr, nxt_rr;
  logic [BEAT_W-1:0]       beat_cnt, nxt_beat;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        win_idx;
  logic [IDX_W-1:0]        win_rr_next;
  logic [MASTER_NUM-1:0]   win_oh;
  logic [IDX_W-1:0]        cand;
  logic                    found;
  int                      sum;
  logic                    any_req;
  logic                    owner_lock;
  logic                    rearb_ok;

  // Encode the one-hot grant into the current owner index
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (hgrant[i]) grant_idx = grant_idx | IDX_W'(i);
    end
  end

  // Winner: lowest requester in fixed mode, first requester from rr_ptr in RR mode
  always_comb begin
    win_idx = DEF_IDX;
    found   = 1'b0;
    cand    = '0;
    sum     = 0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (ARB_MODE == 0) begin
        cand = IDX_W'(i);
      end else begin
        sum = int'(rr_ptr) + i;
        if (sum >= int'(MASTER_NUM)) sum = sum - int'(MASTER_NUM);
        cand = IDX_W'(sum);
      end
      if (!found && hbusreq[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign any_req     = |hbusreq;
  assign win_oh      = MASTER_NUM'(1) << win_idx;
  assign win_rr_next = (win_idx == IDX_W'(MASTER_NUM - 1)) ? '0 : win_idx + IDX_W'(1);
  assign owner_lock  = hlock[grant_idx];
  assign hmastlock   = owner_lock;
  assign rearb_ok    = (htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ) ||
                       ((BURST_LIMIT != 0) && (beat_cnt == BEAT_MAX));

  // Next state, next grant, round-robin pointer and burst beat counter
  always_comb begin
    nxt_state = state_q;
    nxt_grant = hgrant;
    nxt_rr    = rr_ptr;
    nxt_beat  = beat_cnt;
    case (state_q)
      ST_PARK: begin
        if (any_req) begin
          nxt_grant = win_oh;
          nxt_rr    = win_rr_next;
          nxt_state = ST_OWN;
        end else begin
          nxt_grant = DEF_OH;
        end
      end
      ST_OWN, ST_UNLOCK: begin
        nxt_state = ST_OWN;
        if (owner_lock) begin
          nxt_state = ST_LOCKED;
        end else if (rearb_ok) begin
          if (any_req) begin
            nxt_grant = win_oh;
            nxt_rr    = win_rr_next;
          end else begin
            nxt_grant = DEF_OH;
            nxt_state = ST_PARK;
          end
        end
      end
      ST_LOCKED: begin
        if (!owner_lock) nxt_state = ST_UNLOCK;
      end
      default: nxt_state = ST_PARK;
    endcase

    if (nxt_grant != hgrant) begin
      nxt_beat = '0;
    end else if (htrans == HTRANS_NONSEQ) begin
      nxt_beat = BEAT_W'(BEAT_MAX != '0);
    end else if ((htrans == HTRANS_SEQ) && (beat_cnt != BEAT_MAX)) begin
      nxt_beat = beat_cnt + BEAT_W'(1);
    end
  end

  // Registered arbitration state; everything advances only on hready
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= ST_PARK;
      hgrant   <= DEF_OH;
      hmaster  <= HMASTER_W'(DEFAULT_MASTER);
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (hready) begin
      state_q  <= nxt_state;
      hgrant   <= nxt_grant;
      hmaster  <= HMASTER_W'(grant_idx);
      rr_ptr   <= nxt_rr;
      beat_cnt <= nxt_beat;
    end
  end

`ifdef AHB_ARB_SVA_EN
  a_grant_onehot: assert property (@(posedge hclk) disable iff (hreset)
    $onehot(hgrant));

  a_hmaster_follows: assert property (@(posedge hclk) disable iff (hreset)
    (hready && $changed(hgrant)) |=> (hmaster == HMASTER_W'($past(grant_idx))));

  a_mastlock: assert property (@(posedge hclk) disable iff (hreset)
    hmastlock == hlock[grant_idx]);

  a_park_default: assert property (@(posedge hclk) disable iff (hreset)
    (hready && !any_req && ((state_q == ST_PARK) ||
     (((state_q == ST_OWN) || (state_q == ST_UNLOCK)) && !owner_lock && rearb_ok)))
    |=> (hgrant == DEF_OH));

  a_locked_hold: assert property (@(posedge hclk) disable iff (hreset)
    (state_q == ST_LOCKED) |=> $stable(hgrant));
`endif

endmodule
